// File: rtl/dot_product_mac16_if.sv
// Stream bundle for dot_product_mac16: burst start/length, operand input stream,
// result output stream and busy status.
interface dot_product_mac16_if #(
  parameter int ACC_W = 40,
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_a;
  logic [15:0]      in_b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;
  logic             busy;

  modport master (
    output start, len, in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf, busy
  );

  modport slave (
    input  start, len, in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_acc, out_ovf, busy
  );
endinterface

// File: rtl/dot_product_mac16.sv
// Burst dot-product MAC behind a combinational 16x16 unsigned array multiplier.
// Optional feature macro DOT_MAC_SAT_EN: saturate the accumulator on carry-out instead of wrapping.
module mul16x16_array (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [31:0] o_p
);
  always_comb begin
    o_p = '0;
    for (int i = 0; i < 16; i++) begin
      if (i_b[i]) o_p = o_p + ({16'h0000, i_a} << i);
    end
  end
endmodule

module dot_product_mac16 #(
  parameter int ACC_W = 40,
  parameter int LEN_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  dot_product_mac16_if.slave io_bus
);
  localparam int DATA_W = 16;
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [LEN_W-1:0]  r_len, r_accepted;
  logic [DATA_W-1:0] r_a_p0, r_b_p0;
  logic              r_vld_p0, r_last_p0;
  logic [PROD_W-1:0] r_prod_p1;
  logic              r_vld_p1, r_last_p1;
  logic [ACC_W-1:0]  r_acc;
  logic              r_ovf;

  logic [PROD_W-1:0] w_prod;
  logic [ACC_W:0]    w_sum;
  logic              w_in_ready, w_xfer, w_start_ok, w_last_term;

  // Carry lands in the extra top bit so overflow detection needs no second adder.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] acc,
                                             input logic [PROD_W-1:0] prod);
    acc_add = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
  endfunction

  function automatic logic [ACC_W-1:0] acc_limit(input logic [ACC_W:0] sum);
`ifdef DOT_MAC_SAT_EN
    acc_limit = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    acc_limit = sum[ACC_W-1:0];
`endif
  endfunction

  mul16x16_array u_mul (
    .i_a (r_a_p0),
    .i_b (r_b_p0),
    .o_p (w_prod)
  );

  assign w_in_ready  = (r_state == S_RUN) && (r_accepted < r_len);
  assign w_xfer      = w_in_ready && io_bus.in_valid;
  assign w_start_ok  = (r_state == S_IDLE) && io_bus.start;
  assign w_last_term = (r_accepted == (r_len - LEN_W'(1)));
  assign w_sum       = acc_add(r_acc, r_prod_p1);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (io_bus.start) w_state_nxt = (io_bus.len == '0) ? S_DONE : S_RUN;
      S_RUN:   if (r_vld_p1 && r_last_p1) w_state_nxt = S_DONE;
      S_DONE:  if (io_bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_accepted <= '0;
      r_a_p0     <= '0;
      r_b_p0     <= '0;
      r_vld_p0   <= 1'b0;
      r_last_p0  <= 1'b0;
      r_prod_p1  <= '0;
      r_vld_p1   <= 1'b0;
      r_last_p1  <= 1'b0;
      r_acc      <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_ok) begin
        r_len      <= io_bus.len;
        r_accepted <= '0;
      end else if (w_xfer) begin
        r_accepted <= r_accepted + LEN_W'(1);
      end
      // p0: operand capture; the last-term flag rides with the pair
      r_vld_p0  <= w_xfer;
      r_last_p0 <= w_xfer && w_last_term;
      if (w_xfer) begin
        r_a_p0 <= io_bus.in_a;
        r_b_p0 <= io_bus.in_b;
      end
      // p1: product register
      r_vld_p1  <= r_vld_p0;
      r_last_p1 <= r_last_p0;
      if (r_vld_p0) r_prod_p1 <= w_prod;
      // p2: accumulate; pipeline is empty whenever a start is accepted
      if (w_start_ok) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
      end else if (r_vld_p1) begin
        r_acc <= acc_limit(w_sum);
        if (w_sum[ACC_W]) r_ovf <= 1'b1;
      end
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = (r_state == S_DONE);
  assign io_bus.out_acc   = r_acc;
  assign io_bus.out_ovf   = r_ovf;
  assign io_bus.busy      = (r_state != S_IDLE);
endmodule

// File: doc/dot_product_mac16.md
Name: dot_product_mac16

Overview:
- Sequential consumer of the team's combinational 16x16 unsigned array multiplier.
- Accepts a burst of LEN operand pairs over a valid/ready stream and registers each pair into the instantiated multiplier.
- Registers the 32-bit product and accumulates it into a wide accumulator.
- Presents the finished dot product on a valid/ready output; used as the MAC stage behind the multiplier in filter/correlator datapaths.

Parameters:
- ACC_W, 40, accumulator/result width; legal range 32..64.
- LEN_W, 8, width of the burst-length input; max burst = 2^LEN_W-1 terms.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a burst; sampled only in IDLE.
- len  input  LEN_W  number of terms; captured when start is accepted.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block will accept a pair this cycle.
- in_a  input  16  unsigned operand A.
- in_b  input  16  unsigned operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_acc  output  ACC_W  dot-product result.
- out_ovf  output  1  sticky: the accumulator exceeded ACC_W bits during the burst.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE; in_ready=0, out_valid=0, out_acc=0, out_ovf=0, busy=0; all pipeline valids, counters and registers cleared. Reset mid-burst discards the burst with no output.
- Clock and reset: one clock; reset is synchronous and active-high.
- FSM states:
  - IDLE -> RUN on start. len, accepted count=0 and acc=0 are loaded at the same edge.
  - IDLE -> DONE on start with len=0. out_acc=0 and out_valid=1 take effect at the next edge.
  - RUN -> DONE at the edge where the final term is accumulated.
  - DONE -> IDLE on out_valid&&out_ready. out_acc holds its value; out_ovf holds until the next start.
- start outside IDLE is ignored.
- in_ready = (state==RUN) && (accepted < len). It is a registered-state function, with no combinational path from in_valid.
- A transfer occurs when in_valid&&in_ready; accepted increments. Gaps in in_valid are allowed; in_a/in_b are ignored when no transfer occurs.
- Pipeline for a transfer at edge k:
  - edge k: a_r/b_r registered and fed to the multiplier.
  - edge k+1: 32-bit product p_r registered.
  - edge k+2: acc += zero-extended p_r.
  - Throughput is one term per cycle.
- Last term handshaked at edge k: out_valid=1 and out_acc final from edge k+2.
- DONE holds out_valid=1 and a stable out_acc while out_ready=0.
- Arithmetic:
  - unsigned; the sum is computed at ACC_W+1 bits.
  - If the carry is set, out_ovf<=1 (sticky).
  - Without the optional feature, acc wraps modulo 2^ACC_W.
- out_acc reflects the running acc during RUN; it is only meaningful when out_valid=1.

Optional Feature:
- Macro: DOT_MAC_SAT_EN.
- Defined: on carry out, acc saturates to all ones, and further additions keep it all ones for the rest of the burst. out_ovf still sets.
- Undefined: wrap-around as above, out_ovf sticky. Saturation logic is absent.

Test Plan:
- Basic:
  - stimulus: start, len=3, pairs (2,3),(4,5),(6,7) back-to-back, out_ready=1.
  - response: out_valid 2 cycles after the 3rd handshake edge; out_acc=68; out_ovf=0; in_ready=0 after the 3rd transfer.
- Max operands, ACC_W=40:
  - stimulus: len=255, all pairs 0xFFFF x 0xFFFF.
  - response: out_acc=0xFEFE0200FF; out_ovf=0.
- Overflow, ACC_W=32:
  - stimulus: len=2, both pairs 0xFFFF x 0xFFFF.
  - response without DOT_MAC_SAT_EN: out_acc=0xFFFC0002, out_ovf=1.
  - response with DOT_MAC_SAT_EN: out_acc=0xFFFFFFFF, out_ovf=1.
- Backpressure and gaps:
  - stimulus: len=4 with in_valid low on alternate cycles; out_ready held low 5 cycles after out_valid.
  - response: correct sum; out_valid/out_acc stable while stalled; IDLE one edge after out_ready=1.
- len=0 and ignored start:
  - stimulus: start with len=0.
  - response: out_valid=1, out_acc=0 next edge.
  - stimulus: a second start pulsed in RUN.
  - response: no effect on count or result.
- Reset mid-burst:
  - stimulus: rst=1 after 2 of 5 terms.
  - response: all outputs 0 at the next edge; a new burst (1,1) with len=1 gives out_acc=1.
